booth_multiplier: RTL and testbench

BOOTH_MULTIPLIER -- requirements
Module: booth_multiplier

---
 rtl/booth_multiplier.sv | 175 +++++++++++++++++
 tb/tb_booth_multiplier.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/booth_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : booth_multiplier
//  Description : Sequential signed multiplier using Booth recoding. Radix-2
//                (one multiplier bit per cycle) or radix-4 modified Booth
//                (two multiplier bits per cycle), selected by RADIX4.
//  Revision    : 1.0  initial release
// ============================================================================
module booth_multiplier #(
    parameter int WIDTH  = 8,   // operand width, even and >= 4
    parameter int RADIX4 = 0    // 0: radix-2 Booth, 1: radix-4 modified Booth
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    // Two guard bits on the accumulator keep +/-2M and the most-negative
    // operand pair from overflowing.
    localparam int c_acc_w = WIDTH + 2;
    localparam int c_iters = (RADIX4 != 0) ? (WIDTH / 2) : WIDTH;
    localparam int c_cnt_w = $clog2(WIDTH + 1);

    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(c_iters);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;

    logic [c_acc_w-1:0]   r_m;        // sign-extended multiplicand
    logic [c_acc_w-1:0]   r_acc;
    logic [WIDTH-1:0]     r_q;
    logic                 r_qm1;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [2*WIDTH-1:0]   r_product;

    logic [c_acc_w-1:0]   w_addend;
    logic [c_acc_w-1:0]   w_sum;
    logic [c_acc_w-1:0]   w_acc_sh;
    logic [WIDTH-1:0]     w_q_sh;
    logic                 w_qm1_sh;
    logic [2*WIDTH-1:0]   w_product;

    logic                 w_start_ok;
    logic                 w_last_iter;

    assign w_start_ok  = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last_iter = (r_state == RUN) && (r_cnt == c_cnt_last);

    // ------------------------------------------------------------------------
    // Recoding and shift, one flavour per radix
    // ------------------------------------------------------------------------
    generate
        if (RADIX4 != 0) begin : g_radix4
            // Radix-4: examine {Q1,Q0,Q-1}, add the selected digit multiple, shift by 2
            always_comb begin
                w_addend = '0;
                case ({r_q[1], r_q[0], r_qm1})
                    3'b001, 3'b010: w_addend = r_m;
                    3'b011:         w_addend = r_m << 1;
                    3'b100:         w_addend = -(r_m << 1);
                    3'b101, 3'b110: w_addend = -r_m;
                    default:        w_addend = '0;
                endcase
                w_sum    = r_acc + w_addend;
                w_acc_sh = {{2{w_sum[c_acc_w-1]}}, w_sum[c_acc_w-1:2]};
                w_q_sh   = {w_sum[1:0], r_q[WIDTH-1:2]};
                w_qm1_sh = r_q[1];
            end
        end else begin : g_radix2
            // Radix-2: examine {Q0,Q-1}, add/subtract M or nothing, shift by 1
            always_comb begin
                w_addend = '0;
                case ({r_q[0], r_qm1})
                    2'b01:   w_addend = r_m;
                    2'b10:   w_addend = -r_m;
                    default: w_addend = '0;
                endcase
                w_sum    = r_acc + w_addend;
                w_acc_sh = {w_sum[c_acc_w-1], w_sum[c_acc_w-1:1]};
                w_q_sh   = {w_sum[0], r_q[WIDTH-1:1]};
                w_qm1_sh = r_q[0];
            end
        end
    endgenerate

    // The guard bits only carry sign; the low 2*WIDTH bits hold the product.
    assign w_product = {w_acc_sh[WIDTH-1:0], w_q_sh};

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; DONE may chain straight into RUN for back-to-back work
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                if (r_cnt == c_cnt_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = start ? RUN : IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    // Operand capture on accepted start, one Booth step per RUN cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_m   <= '0;
            r_acc <= '0;
            r_q   <= '0;
            r_qm1 <= 1'b0;
            r_cnt <= '0;
        end else if (w_start_ok) begin
            r_m   <= {{2{multiplicand[WIDTH-1]}}, multiplicand};
            r_acc <= '0;
            r_q   <= multiplier;
            r_qm1 <= 1'b0;
            r_cnt <= c_cnt_load;
        end else if (r_state == RUN) begin
            r_acc <= w_acc_sh;
            r_q   <= w_q_sh;
            r_qm1 <= w_qm1_sh;
            r_cnt <= r_cnt - c_cnt_last;
        end
    end

    // Result register, loaded only on the final step so it holds between ops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_product <= '0;
        end else if (w_last_iter) begin
            r_product <= w_product;
        end
    end

    assign busy    = (r_state == RUN);
    assign done    = (r_state == DONE);
    assign product = r_product;

endmodule
`default_nettype wire

// File: tb/tb_booth_multiplier.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_booth_multiplier
//  Description : Directed self-checking bench for booth_multiplier, with one
//                radix-2 and one radix-4 instance sharing clock/reset/operands.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_booth_multiplier;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [1:0]       start_v;
    logic [7:0]       mc;
    logic [7:0]       mp;
    logic [1:0]       busy_v;
    logic [1:0]       done_v;
    logic [1:0][15:0] prod_v;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc;
    int cyc2;

    always #5 clk = ~clk;

    booth_multiplier #(.WIDTH(8), .RADIX4(0)) dut_r2 (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start_v[0]),
        .multiplicand (mc),
        .multiplier   (mp),
        .busy         (busy_v[0]),
        .done         (done_v[0]),
        .product      (prod_v[0])
    );

    booth_multiplier #(.WIDTH(8), .RADIX4(1)) dut_r4 (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start_v[1]),
        .multiplicand (mc),
        .multiplier   (mp),
        .busy         (busy_v[1]),
        .done         (done_v[1]),
        .product      (prod_v[1])
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int iters(input int mode);
        return (mode != 0) ? 4 : 8;
    endfunction

    // Count cycles from the start edge until done, checking busy each cycle
    task automatic wait_done(input int mode, input int cyc0, output int cyc_o);
        cyc_o = cyc0;
        while (done_v[mode] !== 1'b1 && cyc_o < 40) begin
            check("busy_in_run", 16'(busy_v[mode]), 16'd1);
            tick;
            cyc_o++;
        end
        check("busy_at_done", 16'(busy_v[mode]), 16'd0);
    endtask

    task automatic do_mul(input int mode, input logic [7:0] m, input logic [7:0] q,
                          input logic [15:0] exp, input string tag);
        int c;
        mc = m;
        mp = q;
        start_v[mode] = 1'b1;
        tick;
        start_v[mode] = 1'b0;
        wait_done(mode, 0, c);
        check({tag, "_latency"}, 16'(c), 16'(iters(mode)));
        check({tag, "_product"}, prod_v[mode], exp);
        tick;
        check({tag, "_done_pulse"}, 16'(done_v[mode]), 16'd0);
        check({tag, "_product_hold"}, prod_v[mode], exp);
    endtask

    initial begin
        reset_n = 1'b0;
        start_v = 2'b00;
        mc      = 8'd0;
        mp      = 8'd0;
        tick;
        tick;

        // Reset state
        for (int i = 0; i < 2; i++) begin
            check("reset_busy", 16'(busy_v[i]), 16'd0);
            check("reset_done", 16'(done_v[i]), 16'd0);
            check("reset_product", prod_v[i], 16'h0000);
        end
        reset_n = 1'b1;
        tick;

        // Basic products in both modes
        do_mul(0, 8'd7,    8'hFD, 16'hFFEB, "r2_7x-3");
        do_mul(1, 8'd7,    8'hFD, 16'hFFEB, "r4_7x-3");
        do_mul(1, 8'h80,   8'h80, 16'h4000, "r4_-128x-128");
        do_mul(0, 8'h80,   8'h80, 16'h4000, "r2_-128x-128");
        do_mul(0, 8'h80,   8'h7F, 16'hC080, "r2_-128x127");
        do_mul(1, 8'h80,   8'h7F, 16'hC080, "r4_-128x127");
        do_mul(0, 8'h00,   8'hFF, 16'h0000, "r2_0x-1");
        do_mul(1, 8'h00,   8'hFF, 16'h0000, "r4_0x-1");
        do_mul(1, 8'h7F,   8'h7F, 16'h3F01, "r4_127x127");

        // start during RUN with new operands is ignored (25 * -4 = -100)
        do_mul(0, 8'd7, 8'hFD, 16'hFFEB, "r2_prev");
        mc = 8'd25;
        mp = 8'hFC;
        start_v[0] = 1'b1;
        tick;
        start_v[0] = 1'b0;
        tick;
        tick;
        mc = 8'd3;
        mp = 8'd3;
        start_v[0] = 1'b1;
        tick;
        start_v[0] = 1'b0;
        check("ign_busy", 16'(busy_v[0]), 16'd1);
        check("ign_product_unchanged", prod_v[0], 16'hFFEB);
        wait_done(0, 3, cyc);
        check("ign_latency", 16'(cyc), 16'd8);
        check("ign_product", prod_v[0], 16'hFF9C);
        tick;
        tick;
        check("ign_no_restart", 16'(busy_v[0]), 16'd0);
        check("ign_product_hold", prod_v[0], 16'hFF9C);

        // Back-to-back in radix-4: 2*3 then -4*5 with no idle cycle
        mc = 8'd2;
        mp = 8'd3;
        start_v[1] = 1'b1;
        tick;
        wait_done(1, 0, cyc);
        check("b2b_first_latency", 16'(cyc), 16'd4);
        check("b2b_first_product", prod_v[1], 16'h0006);
        mc = 8'hFC;
        mp = 8'd5;
        tick;
        start_v[1] = 1'b0;
        check("b2b_no_idle_busy", 16'(busy_v[1]), 16'd1);
        check("b2b_no_idle_done", 16'(done_v[1]), 16'd0);
        wait_done(1, 0, cyc2);
        check("b2b_gap", 16'(cyc2 + 1), 16'd5);
        check("b2b_second_product", prod_v[1], 16'hFFEC);
        tick;

        // Asynchronous reset in mid-RUN aborts the operation
        mc = 8'd7;
        mp = 8'hFD;
        start_v[0] = 1'b1;
        tick;
        start_v[0] = 1'b0;
        tick;
        tick;
        check("pre_reset_busy", 16'(busy_v[0]), 16'd1);
        reset_n = 1'b0;
        #1;
        check("rst_busy", 16'(busy_v[0]), 16'd0);
        check("rst_done", 16'(done_v[0]), 16'd0);
        check("rst_product_r2", prod_v[0], 16'h0000);
        check("rst_product_r4", prod_v[1], 16'h0000);
        #3;
        reset_n = 1'b1;
        do_mul(0, 8'd5, 8'd6, 16'h001E, "post_rst_5x6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
